relobi_cut: RTL and testbench

RELOBI_CUT -- requirements
Module: relobi_cut

---
 rtl/relobi_cut.sv | 229 ++++++++++++++++++++++
 tb/tb_relobi_cut.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relobi_cut.sv
// relobi_cut: register cut for a triple-redundant ("reliable") OBI link.
//
// The A channel is buffered in a 2-entry FIFO. The R channel is buffered in a
// 2-entry FIFO when Cfg.UseRReady is set, otherwise in a single register stage.
// Payloads are ECC-encoded words and pass through untouched. Triplicated
// handshakes are majority-voted on entry. Every triplicated output bit comes
// from its own flip-flop copy.
//
// Ports
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   sbr_req_i  : request from the upstream relOBI encoder
//   sbr_rsp_o  : response to the upstream encoder (gnt[2:0], rvalid[2:0], r)
//   mgr_req_o  : registered request to the downstream subordinate
//   mgr_rsp_i  : response from the downstream subordinate
//   fault_o    : [0] A-channel vote mismatch or illegal state,
//                [1] R-channel vote mismatch or illegal state
//                (single-cycle pulses, combinational, forced low in reset)

// Minimal bus-configuration package so the block elaborates standalone.
// The request/response structs always carry the rready field; it is ignored
// when UseRReady is clear.
package obi_pkg;
    typedef struct packed {
        logic        UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1, AddrWidth: 32, DataWidth: 32};

    typedef logic [71:0] relobi_a_chan_t;
    typedef logic [38:0] relobi_r_chan_t;

    typedef struct packed {
        logic [2:0]     req;
        relobi_a_chan_t a;
        logic [2:0]     rready;
    } relobi_req_t;

    typedef struct packed {
        logic [2:0]     gnt;
        logic [2:0]     rvalid;
        relobi_r_chan_t r;
    } relobi_rsp_t;
endpackage

// Two-entry FIFO with triplicated, self-scrubbing occupancy.
module relobi_cut_fifo #(
    parameter type data_t = logic
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  data_t      data_i,
    output data_t      data_o,
    output logic [2:0] vld_o,
    output logic [2:0] rdy_o,
    output logic       illegal_o
);
    logic [1:0] occ0_q, occ1_q, occ2_q;
    logic [1:0] occ_vote, occ_cur, occ_d;
    logic       rptr_q, rptr_d, widx;
    logic       push, pop;
    data_t      mem_q [2];

    always_comb begin
        occ_vote  = (occ0_q & occ1_q) | (occ0_q & occ2_q) | (occ1_q & occ2_q);
        // Occupancy 3 cannot happen legitimately; treat it as empty.
        illegal_o = (occ_vote == 2'd3);
        occ_cur   = illegal_o ? 2'd0 : occ_vote;
        // Guard against output-copy upsets: never overfill or underflow.
        push      = push_i && (occ_cur != 2'd2);
        pop       = pop_i  && (occ_cur != 2'd0);
        // The tail sits one slot past the head when exactly one entry is held.
        widx      = rptr_q ^ (occ_cur == 2'd1);
        rptr_d    = rptr_q ^ pop;
        occ_d     = occ_cur + {1'b0, push} - {1'b0, pop};
    end

    // Every replica is rewritten from the voted next value, scrubbing upsets.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) occ0_q <= 2'd0;
        else       occ0_q <= occ_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) occ1_q <= 2'd0;
        else       occ1_q <= occ_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) occ2_q <= 2'd0;
        else       occ2_q <= occ_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rptr_q <= 1'b0;
        else       rptr_q <= rptr_d;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[widx] <= data_i;
    end

    assign data_o = mem_q[rptr_q];

    // One flip-flop per handshake copy, so no copy shares a net with another.
    for (genvar i = 0; i < 3; i++) begin : g_copy
        logic vld_q, rdy_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                rdy_q <= 1'b1;
            end else begin
                vld_q <= (occ_d != 2'd0);
                rdy_q <= (occ_d != 2'd2);
            end
        end
        assign vld_o[i] = vld_q;
        assign rdy_o[i] = rdy_q;
    end
endmodule

module relobi_cut #(
    parameter obi_pkg::obi_cfg_t Cfg = obi_pkg::ObiDefaultConfig,
    parameter type relobi_req_t      = obi_pkg::relobi_req_t,
    parameter type relobi_rsp_t      = obi_pkg::relobi_rsp_t,
    parameter type relobi_a_chan_t   = obi_pkg::relobi_a_chan_t,
    parameter type relobi_r_chan_t   = obi_pkg::relobi_r_chan_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  relobi_req_t sbr_req_i,
    output relobi_rsp_t sbr_rsp_o,
    output relobi_req_t mgr_req_o,
    input  relobi_rsp_t mgr_rsp_i,
    output logic [1:0]  fault_o
);
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic dis3(input logic [2:0] v);
        return (v != 3'b000) && (v != 3'b111);
    endfunction

    logic           a_push, a_pop, a_illegal;
    logic [2:0]     a_vld, a_rdy;
    relobi_a_chan_t a_head;

    logic           r_illegal, r_rready_dis;
    logic [2:0]     r_vld, r_rdy;
    relobi_r_chan_t r_head;

    assign a_push = maj3(sbr_req_i.req) & maj3(a_rdy);
    assign a_pop  = maj3(a_vld) & maj3(mgr_rsp_i.gnt);

    relobi_cut_fifo #(.data_t(relobi_a_chan_t)) i_a_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (a_push),
        .pop_i     (a_pop),
        .data_i    (sbr_req_i.a),
        .data_o    (a_head),
        .vld_o     (a_vld),
        .rdy_o     (a_rdy),
        .illegal_o (a_illegal)
    );

    if (Cfg.UseRReady) begin : gen_r_fifo
        logic r_push, r_pop;
        assign r_push       = maj3(mgr_rsp_i.rvalid) & maj3(r_rdy);
        assign r_pop        = maj3(r_vld) & maj3(sbr_req_i.rready);
        assign r_rready_dis = dis3(sbr_req_i.rready);

        relobi_cut_fifo #(.data_t(relobi_r_chan_t)) i_r_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .push_i    (r_push),
            .pop_i     (r_pop),
            .data_i    (mgr_rsp_i.r),
            .data_o    (r_head),
            .vld_o     (r_vld),
            .rdy_o     (r_rdy),
            .illegal_o (r_illegal)
        );
    end else begin : gen_r_reg
        // Without rready the response is always accepted: a plain delay stage.
        relobi_r_chan_t r_q;
        logic           rvalid_vote;

        assign rvalid_vote  = maj3(mgr_rsp_i.rvalid);
        assign r_rready_dis = 1'b0;
        assign r_illegal    = 1'b0;
        assign r_rdy        = 3'b111;
        assign r_head       = r_q;

        always_ff @(posedge clk_i) begin
            r_q <= mgr_rsp_i.r;
        end

        for (genvar i = 0; i < 3; i++) begin : g_copy
            logic vld_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) vld_q <= 1'b0;
                else       vld_q <= rvalid_vote;
            end
            assign r_vld[i] = vld_q;
        end
    end

    always_comb begin
        mgr_req_o        = '0;
        mgr_req_o.req    = a_vld;
        mgr_req_o.a      = a_head;
        mgr_req_o.rready = r_rdy;

        sbr_rsp_o        = '0;
        sbr_rsp_o.gnt    = a_rdy;
        sbr_rsp_o.rvalid = r_vld;
        sbr_rsp_o.r      = r_head;

        fault_o    = 2'b00;
        fault_o[0] = !rst_i && (dis3(sbr_req_i.req) || dis3(mgr_rsp_i.gnt) || a_illegal);
        fault_o[1] = !rst_i && (dis3(mgr_rsp_i.rvalid) || r_rready_dis || r_illegal);
    end
endmodule

// File: tb/tb_relobi_cut.sv
module tb_relobi_cut;
    import obi_pkg::*;

    localparam logic [2:0] N = 3'b000;
    localparam logic [2:0] Y = 3'b111;
    localparam obi_cfg_t CfgNr = '{UseRReady: 1'b0, AddrWidth: 32, DataWidth: 32};

    logic        clk = 1'b0;
    logic        rst;
    relobi_req_t sbr_req, mgr_req, mgr_req_nr;
    relobi_rsp_t mgr_rsp, sbr_rsp, sbr_rsp_nr;
    logic [1:0]  fault, fault_nr;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    relobi_cut dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sbr_req_i (sbr_req),
        .sbr_rsp_o (sbr_rsp),
        .mgr_req_o (mgr_req),
        .mgr_rsp_i (mgr_rsp),
        .fault_o   (fault)
    );

    relobi_cut #(.Cfg(CfgNr)) dut_nr (
        .clk_i     (clk),
        .rst_i     (rst),
        .sbr_req_i (sbr_req),
        .sbr_rsp_o (sbr_rsp_nr),
        .mgr_req_o (mgr_req_nr),
        .mgr_rsp_i (mgr_rsp),
        .fault_o   (fault_nr)
    );

    function automatic relobi_a_chan_t enc_a(input logic [31:0] addr, input logic [31:0] wdata);
        return {addr, wdata, addr[7:0] ^ wdata[7:0]};
    endfunction

    function automatic relobi_r_chan_t enc_r(input logic [31:0] d);
        return {d, d[6:0] ^ d[31:25]};
    endfunction

    typedef struct {
        logic           rst;
        logic [2:0]     req;
        relobi_a_chan_t a;
        logic [2:0]     rready;
        logic [2:0]     gnt;
        logic [2:0]     rvalid;
        relobi_r_chan_t r;
        logic [2:0]     e_req;
        relobi_a_chan_t e_a;
        logic [2:0]     e_gnt;
        logic [2:0]     e_rvalid;
        relobi_r_chan_t e_r;
        logic [2:0]     e_rready;
        logic [1:0]     e_fault;
        logic [2:0]     e_nr_rvalid;
        relobi_r_chan_t e_nr_r;
        logic [1:0]     e_nr_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_v, input logic [2:0] req, input relobi_a_chan_t a, input logic [2:0] rdy,
        input logic [2:0] gnt, input logic [2:0] rv, input relobi_r_chan_t r,
        input logic [2:0] e_req, input relobi_a_chan_t e_a, input logic [2:0] e_gnt,
        input logic [2:0] e_rv, input relobi_r_chan_t e_r, input logic [2:0] e_rdy,
        input logic [1:0] e_f, input logic [2:0] e_nrv, input relobi_r_chan_t e_nr, input logic [1:0] e_nf);
        vec_t v;
        v.rst = rst_v; v.req = req; v.a = a; v.rready = rdy; v.gnt = gnt; v.rvalid = rv; v.r = r;
        v.e_req = e_req; v.e_a = e_a; v.e_gnt = e_gnt; v.e_rvalid = e_rv; v.e_r = e_r;
        v.e_rready = e_rdy; v.e_fault = e_f; v.e_nr_rvalid = e_nrv; v.e_nr_r = e_nr; v.e_nr_fault = e_nf;
        return v;
    endfunction

    task automatic drive(input logic rst_v, input logic [2:0] req, input relobi_a_chan_t a,
                         input logic [2:0] rdy, input logic [2:0] gnt, input logic [2:0] rv,
                         input relobi_r_chan_t r);
        rst            = rst_v;
        sbr_req        = '0;
        sbr_req.req    = req;
        sbr_req.a      = a;
        sbr_req.rready = rdy;
        mgr_rsp        = '0;
        mgr_rsp.gnt    = gnt;
        mgr_rsp.rvalid = rv;
        mgr_rsp.r      = r;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    relobi_a_chan_t A1, A2, A3, A4, ZA;
    relobi_r_chan_t R1, R2, R3, ZR;

    initial begin
        A1 = enc_a(32'h1000_0040, 32'h0000_0001);
        A2 = enc_a(32'h1000_0044, 32'h2222_2222);
        A3 = enc_a(32'h1000_0048, 32'h3333_3333);
        A4 = enc_a(32'h2000_0000, 32'hCAFE_F00D);
        R1 = enc_r(32'hDEAD_BEEF);
        R2 = enc_r(32'h0123_4567);
        R3 = enc_r(32'h89AB_CDEF);
        ZA = '0;
        ZR = '0;
        drive(1'b1, N, ZA, N, N, N, ZR);

        // Each row: inputs applied after a falling edge, outputs expected before the next rising edge.
        // reset
        vecs.push_back(mk(1, N, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(1, N, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // single write, one-cycle latency, drains back to empty
        vecs.push_back(mk(0, Y, A1, N, Y, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  Y, A1, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // backpressure: third push refused, then in-order drain
        vecs.push_back(mk(0, Y, A2, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, Y, A3, N, N, N, ZR,  Y, A2, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, Y, A4, N, N, N, ZR,  Y, A2, N,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  Y, A2, N,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  Y, A3, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // simultaneous push and pop
        vecs.push_back(mk(0, Y, A1, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, Y, A4, N, Y, N, ZR,  Y, A1, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  Y, A4, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  Y, A4, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // A-channel vote faults
        vecs.push_back(mk(0, 3'b101, A2, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b01,  N, ZR, 2'b01));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  Y, A2, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, 3'b110, N, ZR,  Y, A2, Y,  N, ZR, Y, 2'b01,  N, ZR, 2'b01));
        vecs.push_back(mk(0, 3'b001, A3, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b01,  N, ZR, 2'b01));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // response path with rready held low
        vecs.push_back(mk(0, N, ZA, N, N, Y, R1,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, Y, R2,  N, ZA, Y,  Y, R1, Y, 2'b00,  Y, R1, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  N, ZA, Y,  Y, R1, N, 2'b00,  Y, R2, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  N, ZA, Y,  Y, R1, N, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, Y, N, N, ZR,  N, ZA, Y,  Y, R1, N, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, Y, N, N, ZR,  N, ZA, Y,  Y, R2, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // R-channel vote faults
        vecs.push_back(mk(0, N, ZA, N, N, 3'b011, R3,  N, ZA, Y,  N, ZR, Y, 2'b10,  N, ZR, 2'b10));
        vecs.push_back(mk(0, N, ZA, 3'b100, N, N, ZR,  N, ZA, Y,  Y, R3, Y, 2'b10,  Y, R3, 2'b00));
        vecs.push_back(mk(0, N, ZA, Y, N, N, ZR,  N, ZA, Y,  Y, R3, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        // reset with two entries buffered
        vecs.push_back(mk(0, Y, A1, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, Y, A2, N, N, N, ZR,  Y, A1, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, N, N, ZR,  Y, A1, N,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(1, 3'b101, ZA, N, N, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));
        vecs.push_back(mk(0, N, ZA, N, Y, N, ZR,  N, ZA, Y,  N, ZR, Y, 2'b00,  N, ZR, 2'b00));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].req, vecs[i].a, vecs[i].rready, vecs[i].gnt, vecs[i].rvalid, vecs[i].r);
            #1;
            n_vec++;
            chk($sformatf("row%0d req", i), 72'(mgr_req.req), 72'(vecs[i].e_req));
            if (vecs[i].e_req != N) chk($sformatf("row%0d a", i), mgr_req.a, vecs[i].e_a);
            chk($sformatf("row%0d gnt", i), 72'(sbr_rsp.gnt), 72'(vecs[i].e_gnt));
            chk($sformatf("row%0d rvalid", i), 72'(sbr_rsp.rvalid), 72'(vecs[i].e_rvalid));
            if (vecs[i].e_rvalid != N) chk($sformatf("row%0d r", i), 72'(sbr_rsp.r), 72'(vecs[i].e_r));
            chk($sformatf("row%0d rready", i), 72'(mgr_req.rready), 72'(vecs[i].e_rready));
            chk($sformatf("row%0d fault", i), 72'(fault), 72'(vecs[i].e_fault));
            chk($sformatf("row%0d nr_req", i), 72'(mgr_req_nr.req), 72'(vecs[i].e_req));
            chk($sformatf("row%0d nr_gnt", i), 72'(sbr_rsp_nr.gnt), 72'(vecs[i].e_gnt));
            chk($sformatf("row%0d nr_rvalid", i), 72'(sbr_rsp_nr.rvalid), 72'(vecs[i].e_nr_rvalid));
            if (vecs[i].e_nr_rvalid != N) chk($sformatf("row%0d nr_r", i), 72'(sbr_rsp_nr.r), 72'(vecs[i].e_nr_r));
            chk($sformatf("row%0d nr_fault", i), 72'(fault_nr), 72'(vecs[i].e_nr_fault));
        end

        // Single occupancy replica upset from 1 to 2: outputs hold, replica is rescrubbed.
        @(negedge clk);
        drive(1'b0, Y, A3, N, N, N, ZR);
        @(negedge clk);
        drive(1'b0, N, ZA, N, N, N, ZR);
        force dut.i_a_fifo.occ1_q = 2'd2;
        #1;
        release dut.i_a_fifo.occ1_q;
        n_vec++;
        chk("upset req", 72'(mgr_req.req), 72'(Y));
        chk("upset a", mgr_req.a, A3);
        chk("upset gnt", 72'(sbr_rsp.gnt), 72'(Y));
        @(posedge clk);
        #1;
        n_vec++;
        chk("upset scrub", 72'(dut.i_a_fifo.occ1_q), 72'(2'd1));
        chk("upset req after", 72'(mgr_req.req), 72'(Y));
        chk("upset gnt after", 72'(sbr_rsp.gnt), 72'(Y));
        @(negedge clk);
        drive(1'b0, N, ZA, N, Y, N, ZR);
        @(negedge clk);
        drive(1'b0, N, ZA, N, N, N, ZR);
        #1;
        n_vec++;
        chk("upset drained", 72'(mgr_req.req), 72'(N));

        // All replicas forced to the illegal value 3: flagged, treated as empty, scrubbed to 0.
        @(negedge clk);
        force dut.i_a_fifo.occ0_q = 2'd3;
        force dut.i_a_fifo.occ1_q = 2'd3;
        force dut.i_a_fifo.occ2_q = 2'd3;
        #1;
        release dut.i_a_fifo.occ0_q;
        release dut.i_a_fifo.occ1_q;
        release dut.i_a_fifo.occ2_q;
        n_vec++;
        chk("illegal fault", 72'(fault), 72'(2'b01));
        chk("illegal req", 72'(mgr_req.req), 72'(N));
        @(posedge clk);
        #1;
        n_vec++;
        chk("illegal scrub0", 72'(dut.i_a_fifo.occ0_q), 72'(2'd0));
        chk("illegal scrub2", 72'(dut.i_a_fifo.occ2_q), 72'(2'd0));
        chk("illegal fault clr", 72'(fault), 72'(2'b00));
        chk("illegal req after", 72'(mgr_req.req), 72'(N));
        chk("illegal gnt after", 72'(sbr_rsp.gnt), 72'(Y));
        @(negedge clk);
        drive(1'b0, Y, A4, N, N, N, ZR);
        @(negedge clk);
        drive(1'b0, N, ZA, N, Y, N, ZR);
        #1;
        n_vec++;
        chk("post-illegal req", 72'(mgr_req.req), 72'(Y));
        chk("post-illegal a", mgr_req.a, A4);
        @(negedge clk);
        drive(1'b0, N, ZA, N, N, N, ZR);
        #1;
        n_vec++;
        chk("post-illegal drained", 72'(mgr_req.req), 72'(N));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
